// File: rtl/sher_pkg.sv
`default_nettype none
// ============================================================================
// Module      : sher_pkg
// Description : Shared constants for the Sher-VI datapath arithmetic units
//               (default operand width and add/subtract opcode encoding).
// Revision    : 1.0 - initial release
// ============================================================================
package sher_pkg;

  // Default operand/result width of the datapath adder
  localparam int DEFAULT_WIDTH = 16;

  // Encoding of the sub control input
  localparam logic OP_ADD = 1'b0;
  localparam logic OP_SUB = 1'b1;

endpackage : sher_pkg
`default_nettype wire

// File: rtl/full_adder.sv
`default_nettype none
// ============================================================================
// Module      : full_adder
// Description : One-bit full adder cell, chained into the ripple-carry adder.
// Revision    : 1.0 - initial release
// ============================================================================
module full_adder (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic s,
  output logic cout
);

  // Sum and majority-function carry of the three input bits
  assign s    = a ^ b ^ cin;
  assign cout = (a & b) | (a & cin) | (b & cin);

endmodule : full_adder
`default_nettype wire

// File: rtl/adder.sv
`default_nettype none
// ============================================================================
// Module      : adder
// Description : Registered two's-complement add/subtract unit. Subtraction is
//               A + ~B + 1 through a single ripple chain; result and flags are
//               registered together with one cycle of latency.
// Revision    : 1.0 - initial release
// ============================================================================
module adder
  import sher_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             sub,
  input  logic [WIDTH-1:0] data_A,
  input  logic [WIDTH-1:0] data_B,
  output logic [WIDTH-1:0] data_out,
  output logic             carry,
  output logic             overflow,
  output logic             zero,
  output logic             negative
);

  logic             do_sub;
  logic [WIDTH-1:0] b_eff;     // operand B after conditional inversion
  logic [WIDTH:0]   chain;     // ripple carries; chain[0] is the carry-in
  logic [WIDTH-1:0] sum;
  logic             overflow_next;
  logic             zero_next;

  // B-inversion stage: subtract feeds ~B and a carry-in of 1
  assign do_sub   = (sub == OP_SUB);
  assign b_eff    = data_B ^ {WIDTH{do_sub}};
  assign chain[0] = do_sub;

  generate
    for (genvar i = 0; i < WIDTH; i++) begin : g_ripple
      full_adder u_fa (
        .a    (data_A[i]),
        .b    (b_eff[i]),
        .cin  (chain[i]),
        .s    (sum[i]),
        .cout (chain[i+1])
      );
    end
  endgenerate

  // Signed overflow: like-signed operands producing a result of the other sign
  assign overflow_next = (data_A[WIDTH-1] == b_eff[WIDTH-1]) &&
                         (sum[WIDTH-1] != data_A[WIDTH-1]);
  assign zero_next     = (sum == '0);

  // Output register: captures result and flags every cycle, cleared by async reset
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_out <= '0;
      carry    <= 1'b0;
      overflow <= 1'b0;
      zero     <= 1'b0;
    end else begin
      data_out <= sum;
      carry    <= chain[WIDTH];
      overflow <= overflow_next;
      zero     <= zero_next;
    end
  end

  // Sign flag tracks the registered result directly
  assign negative = data_out[WIDTH-1];

endmodule : adder
`default_nettype wire

// File: tb/tb_adder.sv
`default_nettype none
// ============================================================================
// Module      : tb_adder
// Description : Directed and random self-checking bench for the adder unit.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_adder;

  localparam int WIDTH = 16;

  logic             clk;
  logic             rst_n;
  logic             sub;
  logic [WIDTH-1:0] data_A;
  logic [WIDTH-1:0] data_B;
  logic [WIDTH-1:0] data_out;
  logic             carry;
  logic             overflow;
  logic             zero;
  logic             negative;

  int checks_total  = 0;
  int checks_passed = 0;

  adder #(.WIDTH(WIDTH)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .sub      (sub),
    .data_A   (data_A),
    .data_B   (data_B),
    .data_out (data_out),
    .carry    (carry),
    .overflow (overflow),
    .zero     (zero),
    .negative (negative)
  );

  // 10-unit clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Single comparison point: counts every check, reports mismatches
  task automatic check(input string tag, input logic [31:0] observed,
                       input logic [31:0] expected);
    checks_total++;
    if (observed === expected) begin
      checks_passed++;
    end else begin
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
    end
  endtask

  // Drive one operation between edges, then sample just after the next edge
  task automatic apply(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                       input logic s);
    @(negedge clk);
    data_A = a;
    data_B = b;
    sub    = s;
    @(posedge clk);
    #1;
  endtask

  int ra, rb;
  logic [WIDTH-1:0] exp_out;

  initial begin
    rst_n  = 1'b0;
    sub    = 1'b0;
    data_A = '0;
    data_B = '0;

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    check("rst_out",  data_out, 16'h0000);
    check("rst_zero", zero,     1'b0);
    check("rst_carry", carry,   1'b0);
    check("rst_neg",  negative, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;

    // 123 + (-456) = -333
    apply(16'd123, 16'hFE38, 1'b0);
    check("add_out",   data_out, 16'hFEB3);
    check("add_ovf",   overflow, 1'b0);
    check("add_neg",   negative, 1'b1);
    check("add_carry", carry,    1'b0);

    // -250 - 700 = -950
    apply(16'hFF06, 16'h02BC, 1'b1);
    check("sub_out",  data_out, 16'hFC4A);
    check("sub_zero", zero,     1'b0);
    check("sub_ovf",  overflow, 1'b0);
    check("sub_carry", carry,   1'b1);

    // 32767 + 1 overflows to -32768
    apply(16'h7FFF, 16'h0001, 1'b0);
    check("ovf_add_out", data_out, 16'h8000);
    check("ovf_add_ovf", overflow, 1'b1);
    check("ovf_add_neg", negative, 1'b1);

    // -32768 - 1 overflows to 32767
    apply(16'h8000, 16'h0001, 1'b1);
    check("ovf_sub_out", data_out, 16'h7FFF);
    check("ovf_sub_ovf", overflow, 1'b1);
    check("ovf_sub_neg", negative, 1'b0);

    // 5 - 5 = 0, no borrow
    apply(16'd5, 16'd5, 1'b1);
    check("z_sub_out",   data_out, 16'h0000);
    check("z_sub_zero",  zero,     1'b1);
    check("z_sub_carry", carry,    1'b1);

    // -1 + 1 = 0 with carry-out
    apply(16'hFFFF, 16'h0001, 1'b0);
    check("z_add_out",   data_out, 16'h0000);
    check("z_add_zero",  zero,     1'b1);
    check("z_add_carry", carry,    1'b1);
    check("z_add_ovf",   overflow, 1'b0);

    // Reset asserted between edges clears outputs immediately
    apply(16'd7, 16'd9, 1'b0);
    check("pre_rst_out", data_out, 16'd16);
    @(negedge clk);
    data_A = 16'd10;
    data_B = 16'd20;
    sub    = 1'b0;
    #1 rst_n = 1'b0;
    #1;
    check("mid_rst_out",   data_out, 16'h0000);
    check("mid_rst_zero",  zero,     1'b0);
    check("mid_rst_carry", carry,    1'b0);
    check("mid_rst_ovf",   overflow, 1'b0);
    #1 rst_n = 1'b1;
    #1;
    check("post_rel_hold", data_out, 16'h0000);
    @(posedge clk);
    #1;
    check("post_rel_out",  data_out, 16'd30);
    check("post_rel_zero", zero,     1'b0);

    // Random back-to-back operations in +/-1000
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      ra = int'($urandom_range(0, 2000)) - 1000;
      rb = int'($urandom_range(0, 2000)) - 1000;
      sub    = 1'($urandom_range(0, 1));
      data_A = ra[WIDTH-1:0];
      data_B = rb[WIDTH-1:0];
      exp_out = sub ? 16'(ra - rb) : 16'(ra + rb);
      @(posedge clk);
      #1;
      check("rand_out", data_out, exp_out);
      check("rand_ovf", overflow, 1'b0);
    end

    $display("%0d/%0d checks passed", checks_passed, checks_total);
    $finish;
  end

endmodule : tb_adder
`default_nettype wire
